// File: rtl/mem_wb_stage_pkg.sv
// Shared pipeline definitions for the MEM/WB stage: control-bit positions,
// FSM encoding, writeback record and default ack timeout.
package mem_wb_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  // MEMM = {branch, mem_read, mem_write}
  localparam int MEMM_BRANCH = 2;
  localparam int MEMM_READ   = 1;
  localparam int MEMM_WRITE  = 0;

  // MEMWB = {reg_write, mem_to_reg}
  localparam int MEMWB_REG_WRITE  = 1;
  localparam int MEMWB_MEM_TO_REG = 0;

  localparam int TIMEOUT_DEFAULT = 16;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [1:0]        wb;
    logic [DATA_W-1:0] data;
  } wb_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-memory request/ack bus between the MEM stage (master) and memory (slave).
// A request is held stable from dmem_req rising until the cycle dmem_ack is seen.
interface mem_wb_stage_if;
  import mem_wb_stage_pkg::*;

  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_wb_stage_reg.sv
// MEM/WB pipeline register: 1-cycle latency; holds while load=0 (stall),
// and a bubble load clears the record so nothing is written back.
module mem_wb_reg
  import mem_wb_stage_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic              bubble,
  input  wb_t               wb_in,
  output logic [REG_W-1:0]  WBRegRd,
  output logic [1:0]        WBWB,
  output logic [DATA_W-1:0] WBWriteData
);

  wb_t wb_q, wb_d;

  always_comb begin
    wb_d = wb_q;
    if (load) begin
      wb_d = bubble ? '0 : wb_in;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wb_q <= '0;
    end else begin
      wb_q <= wb_d;
    end
  end

  assign WBRegRd     = wb_q.rd;
  assign WBWB        = wb_q.wb;
  assign WBWriteData = wb_q.data;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage + MEM/WB register: 1-cycle latency without a memory op, else accept + wait-for-ack.
// mem_stall freezes upstream from accept until the ack (or timeout) cycle.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [2:0]        MEMM,
  input  logic [1:0]        MEMWB,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  input  logic [REG_W-1:0]  MEMRegRd,
  mem_wb_stage_if.master    dmem,
  output logic              mem_stall,
  output logic              align_error,
  output logic              mem_timeout,
  output logic [REG_W-1:0]  WBRegRd,
  output logic [1:0]        WBWB,
  output logic [DATA_W-1:0] WBWriteData
);

  localparam logic [4:0] CNT_LAST = 5'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              dmem_req_q, dmem_req_d;
  logic              dmem_we_q, dmem_we_d;
  logic [DATA_W-1:0] dmem_addr_q, dmem_addr_d;
  logic [DATA_W-1:0] dmem_wdata_q, dmem_wdata_d;
  logic              align_error_q, align_error_d;
  logic              mem_timeout_q, mem_timeout_d;

  logic mem_op, aligned, start, misalign, ack_hit, to_hit;
  logic wb_load, wb_bubble;
  wb_t  wb_in;
  logic unused_branch;

  // Branch resolves earlier in the pipe; it only rides along here.
  assign unused_branch = MEMM[MEMM_BRANCH];

  assign mem_op   = MEMM[MEMM_READ] | MEMM[MEMM_WRITE];
  assign aligned  = (alu_result[1:0] == 2'b00);
  assign start    = (state_q == ST_IDLE) & in_valid & mem_op & aligned;
  assign misalign = (state_q == ST_IDLE) & in_valid & mem_op & ~aligned;
  assign ack_hit  = (state_q == ST_ACCESS) & dmem.dmem_ack;
  assign to_hit   = (state_q == ST_ACCESS) & ~dmem.dmem_ack & (cnt_q == CNT_LAST);

  assign mem_stall = reset_n & (start | ((state_q == ST_ACCESS) & ~ack_hit & ~to_hit));

  assign wb_load   = ~mem_stall;
  assign wb_bubble = ~in_valid | misalign | to_hit;

  always_comb begin
    wb_in.rd   = MEMRegRd;
    wb_in.wb   = {MEMWB[MEMWB_REG_WRITE] & ~MEMM[MEMM_WRITE] & (MEMRegRd != '0),
                  MEMWB[MEMWB_MEM_TO_REG]};
    wb_in.data = MEMWB[MEMWB_MEM_TO_REG] ? dmem.dmem_rdata : alu_result;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    dmem_req_d    = dmem_req_q;
    dmem_we_d     = dmem_we_q;
    dmem_addr_d   = dmem_addr_q;
    dmem_wdata_d  = dmem_wdata_q;
    align_error_d = misalign;
    mem_timeout_d = mem_timeout_q | to_hit;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_ACCESS;
          cnt_d        = '0;
          dmem_req_d   = 1'b1;
          dmem_we_d    = MEMM[MEMM_WRITE];
          dmem_addr_d  = alu_result;
          dmem_wdata_d = store_data;
        end
      end
      ST_ACCESS: begin
        if (ack_hit || to_hit) begin
          state_d    = ST_IDLE;
          cnt_d      = '0;
          dmem_req_d = 1'b0;
          dmem_we_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      dmem_req_q    <= 1'b0;
      dmem_we_q     <= 1'b0;
      dmem_addr_q   <= '0;
      dmem_wdata_q  <= '0;
      align_error_q <= 1'b0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      dmem_req_q    <= dmem_req_d;
      dmem_we_q     <= dmem_we_d;
      dmem_addr_q   <= dmem_addr_d;
      dmem_wdata_q  <= dmem_wdata_d;
      align_error_q <= align_error_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign dmem.dmem_req   = dmem_req_q;
  assign dmem.dmem_we    = dmem_we_q;
  assign dmem.dmem_addr  = dmem_addr_q;
  assign dmem.dmem_wdata = dmem_wdata_q;
  assign align_error     = align_error_q;
  assign mem_timeout     = mem_timeout_q;

  mem_wb_reg u_mem_wb_reg (
    .clock       (clock),
    .reset_n     (reset_n),
    .load        (wb_load),
    .bubble      (wb_bubble),
    .wb_in       (wb_in),
    .WBRegRd     (WBRegRd),
    .WBWB        (WBWB),
    .WBWriteData (WBWriteData)
  );

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: inputs driven 2ns after the rising edge,
// outputs sampled on the falling edge against hand-computed values.
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic [2:0]  MEMM;
  logic [1:0]  MEMWB;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  MEMRegRd;
  logic        mem_stall, align_error, mem_timeout;
  logic [4:0]  WBRegRd;
  logic [1:0]  WBWB;
  logic [31:0] WBWriteData;

  int n_checks = 0;
  int n_errors = 0;

  mem_wb_stage_if dif ();

  mem_wb_stage #(.TIMEOUT_CYCLES(16)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .MEMM        (MEMM),
    .MEMWB       (MEMWB),
    .alu_result  (alu_result),
    .store_data  (store_data),
    .MEMRegRd    (MEMRegRd),
    .dmem        (dif),
    .mem_stall   (mem_stall),
    .align_error (align_error),
    .mem_timeout (mem_timeout),
    .WBRegRd     (WBRegRd),
    .WBWB        (WBWB),
    .WBWriteData (WBWriteData)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [2:0] m, input logic [1:0] w,
                     input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd);
    in_valid   = v;
    MEMM       = m;
    MEMWB      = w;
    alu_result = a;
    store_data = sd;
    MEMRegRd   = rd;
  endtask

  task automatic nxt();
    @(posedge clock);
    #2;
  endtask

  task automatic smp();
    @(negedge clock);
  endtask

  initial begin
    reset_n        = 1'b0;
    dif.dmem_ack   = 1'b0;
    dif.dmem_rdata = 32'h0;
    drv(1, 3'b010, 2'b11, 32'h10, 32'h0, 5'd3);

    // reset state, with a live aligned load presented
    nxt(); smp();
    chk("rst_stall", mem_stall, 0);
    chk("rst_req", dif.dmem_req, 0);
    chk("rst_we", dif.dmem_we, 0);
    chk("rst_addr", dif.dmem_addr, 0);
    chk("rst_wdata", dif.dmem_wdata, 0);
    chk("rst_wbrd", WBRegRd, 0);
    chk("rst_wbwb", WBWB, 0);
    chk("rst_wbdata", WBWriteData, 0);
    chk("rst_align", align_error, 0);
    chk("rst_tmo", mem_timeout, 0);
    nxt(); reset_n = 1'b1; drv(0, 3'b000, 2'b00, 0, 0, 0);
    smp();
    chk("idle_stall", mem_stall, 0);

    // add
    nxt(); drv(1, 3'b000, 2'b10, 32'd9, 0, 5'd14); smp();
    chk("add_stall", mem_stall, 0);
    nxt(); drv(0, 3'b000, 2'b00, 0, 0, 0); smp();
    chk("add_wbrd", WBRegRd, 14);
    chk("add_wbwb", WBWB, 2'b10);
    chk("add_wbdata", WBWriteData, 9);
    chk("add_stall2", mem_stall, 0);

    // write to x0 is suppressed
    nxt(); drv(1, 3'b000, 2'b10, 32'h55, 0, 5'd0); smp();
    nxt(); drv(0, 3'b000, 2'b00, 0, 0, 0); smp();
    chk("x0_wbwb", WBWB, 2'b00);
    chk("x0_wbdata", WBWriteData, 32'h55);

    // branch without reg_write
    nxt(); drv(1, 3'b100, 2'b00, 32'd5, 0, 5'd9); smp();
    chk("br_stall", mem_stall, 0);
    chk("br_req", dif.dmem_req, 0);
    nxt(); drv(0, 3'b000, 2'b00, 0, 0, 0); smp();
    chk("br_wbwb", WBWB, 2'b00);
    chk("br_wbrd", WBRegRd, 9);

    // lw, ack in the third ACCESS cycle
    nxt(); drv(1, 3'b010, 2'b11, 32'h10, 0, 5'd3); smp();
    chk("lw_c0_stall", mem_stall, 1);
    chk("lw_c0_req", dif.dmem_req, 0);
    nxt(); smp();
    chk("lw_a1_req", dif.dmem_req, 1);
    chk("lw_a1_stall", mem_stall, 1);
    chk("lw_a1_addr", dif.dmem_addr, 32'h10);
    chk("lw_a1_we", dif.dmem_we, 0);
    nxt(); smp();
    chk("lw_a2_req", dif.dmem_req, 1);
    chk("lw_a2_stall", mem_stall, 1);
    nxt(); dif.dmem_ack = 1'b1; dif.dmem_rdata = 32'hDEADBEEF; smp();
    chk("lw_a3_req", dif.dmem_req, 1);
    chk("lw_a3_stall", mem_stall, 0);
    nxt(); dif.dmem_ack = 1'b0; drv(0, 3'b000, 2'b00, 0, 0, 0); smp();
    chk("lw_req_off", dif.dmem_req, 0);
    chk("lw_wbrd", WBRegRd, 3);
    chk("lw_wbwb", WBWB, 2'b11);
    chk("lw_wbdata", WBWriteData, 32'hDEADBEEF);

    // sw with immediate ack; reg_write requested but forced off
    nxt(); drv(1, 3'b001, 2'b10, 32'h18, 32'd14, 5'd5); smp();
    chk("sw_c0_stall", mem_stall, 1);
    nxt(); dif.dmem_ack = 1'b1; smp();
    chk("sw_req", dif.dmem_req, 1);
    chk("sw_we", dif.dmem_we, 1);
    chk("sw_wdata", dif.dmem_wdata, 14);
    chk("sw_addr", dif.dmem_addr, 32'h18);
    chk("sw_stall", mem_stall, 0);
    nxt(); dif.dmem_ack = 1'b0; drv(0, 3'b000, 2'b00, 0, 0, 0); smp();
    chk("sw_wbwb", WBWB, 2'b00);
    chk("sw_req_off", dif.dmem_req, 0);
    chk("sw_we_off", dif.dmem_we, 0);

    // misaligned lw right behind an add
    nxt(); drv(1, 3'b000, 2'b10, 32'd7, 0, 5'd2); smp();
    nxt(); drv(1, 3'b010, 2'b11, 32'h13, 0, 5'd7); smp();
    chk("mis_stall", mem_stall, 0);
    chk("mis_req", dif.dmem_req, 0);
    chk("mis_prev_wbwb", WBWB, 2'b10);
    nxt(); drv(0, 3'b000, 2'b00, 0, 0, 0); smp();
    chk("mis_align", align_error, 1);
    chk("mis_wbwb", WBWB, 2'b00);
    chk("mis_req2", dif.dmem_req, 0);
    nxt(); smp();
    chk("mis_align_pulse", align_error, 0);

    // ack while idle is ignored
    nxt(); dif.dmem_ack = 1'b1; smp();
    chk("idle_ack_req", dif.dmem_req, 0);
    chk("idle_ack_stall", mem_stall, 0);
    nxt(); dif.dmem_ack = 1'b0; smp();
    chk("idle_ack_req2", dif.dmem_req, 0);

    // timeout after 16 ACCESS cycles without ack
    nxt(); drv(1, 3'b000, 2'b10, 32'h77, 0, 5'd6); smp();
    nxt(); drv(1, 3'b010, 2'b11, 32'h20, 0, 5'd4); smp();
    chk("to_c0_stall", mem_stall, 1);
    for (int k = 1; k <= 16; k++) begin
      nxt(); smp();
      chk($sformatf("to_a%0d_stall", k), mem_stall, (k < 16) ? 1 : 0);
      chk($sformatf("to_a%0d_req", k), dif.dmem_req, 1);
    end
    chk("to_pre_tmo", mem_timeout, 0);
    chk("to_hold_wbwb", WBWB, 2'b10);
    nxt(); drv(0, 3'b000, 2'b00, 0, 0, 0); smp();
    chk("to_tmo", mem_timeout, 1);
    chk("to_req", dif.dmem_req, 0);
    chk("to_wbwb", WBWB, 2'b00);
    chk("to_stall", mem_stall, 0);
    nxt(); smp();
    chk("to_sticky", mem_timeout, 1);

    // reset clears the sticky timeout
    nxt(); reset_n = 1'b0; smp();
    nxt(); reset_n = 1'b1; smp();
    chk("rst2_tmo", mem_timeout, 0);

    // ack exactly on the 16th ACCESS cycle wins over timeout
    nxt(); drv(1, 3'b010, 2'b11, 32'h24, 0, 5'd8);
    for (int k = 1; k <= 16; k++) begin
      nxt();
      if (k == 16) begin
        dif.dmem_ack   = 1'b1;
        dif.dmem_rdata = 32'hCAFE0001;
      end
      smp();
    end
    chk("ack16_stall", mem_stall, 0);
    nxt(); dif.dmem_ack = 1'b0; drv(0, 3'b000, 2'b00, 0, 0, 0); smp();
    chk("ack16_tmo", mem_timeout, 0);
    chk("ack16_wbwb", WBWB, 2'b11);
    chk("ack16_wbdata", WBWriteData, 32'hCAFE0001);
    chk("ack16_wbrd", WBRegRd, 8);
    chk("ack16_req", dif.dmem_req, 0);

    // reset during ACCESS cycle 2 aborts the access; later ack ignored
    nxt(); drv(1, 3'b000, 2'b10, 32'h99, 0, 5'd10);
    nxt(); drv(1, 3'b010, 2'b11, 32'h30, 0, 5'd11);
    nxt(); smp();
    chk("rab_a1_req", dif.dmem_req, 1);
    chk("rab_a1_wbwb", WBWB, 2'b10);
    nxt(); reset_n = 1'b0; smp();
    chk("rab_rst_stall", mem_stall, 0);
    nxt(); reset_n = 1'b1; drv(0, 3'b000, 2'b00, 0, 0, 0);
    dif.dmem_ack = 1'b1; dif.dmem_rdata = 32'h12345678; smp();
    chk("rab_req", dif.dmem_req, 0);
    chk("rab_stall", mem_stall, 0);
    chk("rab_wbwb", WBWB, 2'b00);
    chk("rab_wbrd", WBRegRd, 0);
    chk("rab_wbdata", WBWriteData, 0);
    chk("rab_addr", dif.dmem_addr, 0);
    chk("rab_tmo", mem_timeout, 0);
    chk("rab_align", align_error, 0);
    nxt(); dif.dmem_ack = 1'b0; smp();
    chk("rab_post_wbwb", WBWB, 2'b00);
    chk("rab_post_wbdata", WBWriteData, 0);
    chk("rab_post_req", dif.dmem_req, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock, rising edge; reset_n  in  1  synchronous, active-low reset.
REQ-002 SHALL have ports: in_valid  in  1  EX/MEM holds a live instruction; MEMM  in  3  {branch, mem_read, mem_write}; MEMWB  in  2  {reg_write, mem_to_reg}.
REQ-003 SHALL have ports: alu_result  in  32  address or ALU value; store_data  in  32  store operand; MEMRegRd  in  5  destination register.
REQ-004 SHALL have ports: dmem_req  out  1; dmem_we  out  1; dmem_addr  out  32; dmem_wdata  out  32; dmem_ack  in  1; dmem_rdata  in  32.
REQ-005 SHALL have ports: mem_stall  out  1  freeze IF/ID/EX/MEM; align_error  out  1  one-cycle pulse; mem_timeout  out  1  sticky.
REQ-006 SHALL have ports: WBRegRd  out  5; WBWB  out  2; WBWriteData  out  32; all three feed the decode-stage register-file write port and forwarding.
REQ-007 SHALL have parameter: TIMEOUT_CYCLES, default 16, maximum ack wait in cycles.

Function
REQ-008 SHALL implement FSM states IDLE and ACCESS.
REQ-009 IDLE, in_valid=1, no memory op: WBRegRd/WBWB/WBWriteData SHALL update at the next edge (1-cycle latency); mem_stall=0.
REQ-010 IDLE, in_valid=1, mem_read or mem_write, alu_result[1:0]=00: SHALL enter ACCESS at the next edge; mem_stall SHALL be 1 combinationally in that cycle.
REQ-011 ACCESS: dmem_req=1 (registered); dmem_addr=alu_result, dmem_wdata=store_data, dmem_we=mem_write, all held stable until ack; mem_stall=1 until the ack cycle.
REQ-012 dmem_ack SHALL be sampled only in ACCESS; ack in IDLE SHALL be ignored.
REQ-013 Ack in ACCESS: mem_stall=0 in that cycle; MEM/WB SHALL load at that edge (load data = dmem_rdata); FSM SHALL return to IDLE; dmem_req SHALL be 0 from the next cycle.
REQ-014 Writeback data SHALL be dmem_rdata when mem_to_reg=1, else alu_result.
REQ-015 WBWB[1] (reg_write) SHALL be forced 0 for stores, for MEMRegRd=0, and when in_valid=0 (bubble).
REQ-016 Misaligned access (alu_result[1:0]!=00): no dmem_req; align_error pulses one cycle; MEM/WB loads a bubble (WBWB=00); no stall.
REQ-017 A 5-bit wait counter SHALL count ACCESS cycles; at TIMEOUT_CYCLES without ack: mem_timeout set (sticky until reset), dmem_req dropped, MEM/WB loads a bubble, FSM returns to IDLE.
REQ-018 Simultaneous ack and timeout cycle: ack SHALL win; mem_timeout not set.
REQ-019 Branch bit SHALL NOT affect this stage beyond pass-through suppression: branch with reg_write=0 SHALL yield WBWB[1]=0.

Reset
REQ-020 reset_n=0 at an edge: FSM=IDLE, wait counter=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, WBRegRd=0, WBWB=00, WBWriteData=0, align_error=0, mem_timeout=0.
REQ-021 Reset during ACCESS SHALL abort the access: dmem_req low after that edge; a later ack SHALL be ignored.
REQ-022 mem_stall SHALL be 0 while reset_n=0.

Structure
REQ-023 MEMM/MEMWB bit indices, FSM state encoding and TIMEOUT_CYCLES default SHALL live in the shared pipeline package.
REQ-024 MEM/WB register SHALL be a sub-module mem_wb_reg (load, bubble, outputs WBRegRd/WBWB/WBWriteData); FSM and mux stay in mem_wb_stage.

Verification
REQ-025 add: alu_result=9, MEMRegRd=14, MEMWB=10, no mem op -> next cycle WBRegRd=14, WBWB=10, WBWriteData=9, mem_stall=0 throughout.
REQ-026 lw: alu_result=0x10, MEMM=010, MEMWB=11, MEMRegRd=3, ack after 3 ACCESS cycles with rdata=0xDEADBEEF -> dmem_req high 3 cycles, mem_stall high 3 cycles (incl. accept cycle, excl. ack cycle), then WBRegRd=3, WBWriteData=0xDEADBEEF.
REQ-027 sw: alu_result=0x18, store_data=14, MEMM=001, immediate ack -> dmem_we=1, dmem_wdata=14, WBWB[1]=0.
REQ-028 lw with alu_result=0x13 -> no dmem_req, align_error one pulse, WBWB=00.
REQ-029 lw, no ack for 16 cycles -> mem_timeout=1, dmem_req=0, WBWB=00; ack on 16th cycle instead -> normal load, mem_timeout=0.
REQ-030 reset_n=0 during ACCESS cycle 2, ack 1 cycle later -> all outputs at reset values, ack ignored.
